// File: rtl/avl_bus_arbiter.sv
// Round-robin arbiter that shares one Avalon-style slave among MASTER_NUM masters.
// An in-order FIFO routes each read response back to the master that issued the read.
module avl_bus_arbiter #(
  parameter int MASTER_NUM      = 8,
  parameter int RESP_FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rest,
  input  logic [MASTER_NUM-1:0]                m_read,
  input  logic [MASTER_NUM-1:0]                m_write,
  input  logic [32*MASTER_NUM-1:0]             m_address,
  input  logic [4*MASTER_NUM-1:0]              m_byte_en,
  input  logic [32*MASTER_NUM-1:0]             m_write_data,
  output logic [MASTER_NUM-1:0]                m_request_ready,
  output logic [32*MASTER_NUM-1:0]             m_read_data,
  output logic [MASTER_NUM-1:0]                m_read_data_valid,
  input  logic [MASTER_NUM-1:0]                m_resp_ready,
  output logic                                 s_read,
  output logic                                 s_write,
  output logic [31:0]                          s_address,
  output logic [3:0]                           s_byte_en,
  output logic [31:0]                          s_write_data,
  input  logic                                 s_request_ready,
  input  logic [31:0]                          s_read_data,
  input  logic                                 s_read_data_valid,
  output logic                                 s_resp_ready,
  output logic [$clog2(RESP_FIFO_DEPTH):0]     outstanding,
  output logic                                 resp_err,
  output logic                                 arb_state
);

  // Handshakes: a command transfers on a cycle where s_read|s_write and s_request_ready
  // are both high; a response transfers where s_read_data_valid and s_resp_ready are both
  // high. The master sees the same pair as its m_* request/m_request_ready and
  // m_read_data_valid/m_resp_ready bits.

  localparam int IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int AW = $clog2(RESP_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   ptr, ptr_next, gh, gh_next;
  logic [IW-1:0]   rr_idx, g, g_inc;
  logic [MASTER_NUM-1:0] req;
  logic            g_req, g_read, g_write;
  logic            accept, push, pop;
  logic            fifo_full, fifo_empty;
  logic [IW-1:0]   mem [RESP_FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [IW-1:0]   head;

  assign req = m_read | m_write;

  // First requester at or after ptr, wrapping round the master list.
  always_comb begin : rr_search
    int            j;
    logic          found;
    logic [IW-1:0] jj;
    j      = 0;
    jj     = '0;
    found  = 1'b0;
    rr_idx = ptr;
    for (int k = 0; k < MASTER_NUM; k++) begin
      j = int'(ptr) + k;
      if (j >= MASTER_NUM) j = j - MASTER_NUM;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found  = 1'b1;
        rr_idx = jj;
      end
    end
  end

  assign g       = (state == HOLD) ? gh : rr_idx;
  assign g_inc   = (int'(g) == MASTER_NUM - 1) ? '0 : g + IW'(1);
  assign g_req   = req[g];
  assign g_read  = m_read[g];
  assign g_write = m_write[g] & ~m_read[g];

  assign fifo_full  = (count == CW'(RESP_FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // State register
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state <= IDLE;
      ptr   <= '0;
      gh    <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      gh    <= gh_next;
    end
  end

  // Next-state logic; a blocked read stays in HOLD on the same master.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    gh_next    = gh;
    if (accept) begin
      state_next = IDLE;
      ptr_next   = g_inc;
    end else if (state == IDLE) begin
      if (g_req) begin
        state_next = HOLD;
        gh_next    = g;
      end
    end else if (!g_req) begin
      state_next = IDLE;
    end
  end

  // Output logic
  always_comb begin
    s_read          = 1'b0;
    s_write         = 1'b0;
    accept          = 1'b0;
    m_request_ready = '0;
    s_address       = m_address[32*g +: 32];
    s_byte_en       = m_byte_en[4*g +: 4];
    s_write_data    = m_write_data[32*g +: 32];
    if (!rest) begin
      s_read  = g_read & ~fifo_full;
      s_write = g_write;
      accept  = s_request_ready & g_req & ~(g_read & fifo_full);
    end
    m_request_ready[g] = accept;
  end

  assign arb_state = state;

  // Response FIFO holding the owner index of every read issued to the slave.
  assign push = accept & g_read;
  assign head = mem[rd_ptr];

  always_comb begin
    m_read_data_valid = '0;
    s_resp_ready      = 1'b1;
    if (!fifo_empty) begin
      s_resp_ready = m_resp_ready[head];
      if (!rest) m_read_data_valid[head] = s_read_data_valid;
    end
  end

  assign pop         = s_read_data_valid & s_resp_ready & ~fifo_empty;
  assign m_read_data = {MASTER_NUM{s_read_data}};
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= g;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (s_read_data_valid && fifo_empty) resp_err <= 1'b1;
    end
  end

endmodule
